// File: rtl/llsc_mem_unit_pkg.sv
// Shared definitions for the LL/SC memory-access helper.
//   op_e      : MEM-stage memory operation encoding carried on op_i
//   LLBIT_RST : committed LLbit value after reset
//   WORD_LSB  : number of address LSBs dropped to form a word address
package llsc_mem_unit_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_LL    = 2'b01,
    OP_SC    = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  localparam logic        LLBIT_RST = 1'b0;
  localparam int unsigned WORD_LSB  = 2;

endpackage

// File: rtl/llsc_mem_unit_llbit.sv
// Committed LLbit and link address (the architectural copy, as written back
// by the WB-equivalent commit).
//   clk, rst  : core clock, asynchronous active-high reset
//   flush_i   : exception/ERET flush; clears LLbit, keeps the link address
//   commit_i  : write llbit_i/link_i into the committed registers
//   llbit_i   : LLbit value being committed
//   link_i    : link word address being committed
//   llbit_o   : committed LLbit
//   link_o    : committed link word address
module llbit_reg
  import llsc_mem_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              commit_i,
  input  logic              llbit_i,
  input  logic [ADDR_W-1:0] link_i,
  output logic              llbit_o,
  output logic [ADDR_W-1:0] link_o
);

  logic              llbit_q;
  logic [ADDR_W-1:0] link_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_q <= LLBIT_RST;
      link_q  <= '0;
    end else if (flush_i) begin
      llbit_q <= 1'b0;
    end else if (commit_i) begin
      llbit_q <= llbit_i;
      link_q  <= link_i;
    end
  end

  assign llbit_o = llbit_q;
  assign link_o  = link_q;

endmodule

// File: rtl/llsc_mem_unit.sv
// MEM-stage LL/SC helper: turns load/LL/SC/store requests into data_ram
// strobes, owns the LLbit and link address, and returns the SC status.
// A one-entry pending stage (mirroring MEM/WB) is forwarded so that
// back-to-back LL/SC pairs observe the most recent LLbit.
//   clk, rst     : core clock, asynchronous active-high reset
//   req_valid_i  : MEM stage holds a memory instruction
//   op_i         : 00 load, 01 LL, 10 SC, 11 store
//   addr_i       : effective address
//   wdata_i      : store data
//   stall_i      : freeze all state, suppress writes
//   flush_i      : kill request, clear LLbit, drop pending update
//   mem_rdata_i  : data_ram combinational read data
//   mem_ce_o/mem_we_o/mem_addr_o/mem_sel_o/mem_data_o : data_ram interface
//   result_o     : load data or SC status
//   llbit_o      : forwarded LLbit
//   link_addr_o  : forwarded link word address
module llsc_mem_unit
  import llsc_mem_unit_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          CHECK_ADDR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_sel_o,
  output logic [31:0]       mem_data_o,
  output logic [31:0]       result_o,
  output logic              llbit_o,
  output logic [ADDR_W-1:0] link_addr_o
);

  logic              pend_valid_q, pend_valid_d;
  logic              pend_val_q,   pend_val_d;
  logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;

  logic              llbit_c;
  logic [ADDR_W-1:0] link_c;
  logic              eff_ll;
  logic [ADDR_W-1:0] eff_link;
  logic [ADDR_W-1:0] word_addr;
  logic              active;
  logic              link_hit;
  logic              commit;
  logic              unused_addr_lsbs;

  assign word_addr        = {addr_i[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
  assign unused_addr_lsbs = ^addr_i[WORD_LSB-1:0];

  // Forward the not-yet-committed update over the committed copy.
  assign eff_ll   = pend_valid_q ? pend_val_q  : llbit_c;
  assign eff_link = pend_valid_q ? pend_addr_q : link_c;

  assign llbit_o     = eff_ll;
  assign link_addr_o = eff_link;

  assign active   = req_valid_i && !flush_i && !rst;
  assign link_hit = (word_addr == eff_link);

  always_comb begin
    mem_ce_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_sel_o    = '0;
    mem_data_o   = '0;
    result_o     = '0;
    pend_valid_d = 1'b0;
    pend_val_d   = 1'b0;
    pend_addr_d  = eff_link;
    if (active) begin
      unique case (op_e'(op_i))
        OP_LOAD: begin
          mem_ce_o   = 1'b1;
          mem_addr_o = word_addr;
          mem_sel_o  = 4'hF;
          result_o   = mem_rdata_i;
        end
        OP_LL: begin
          mem_ce_o     = 1'b1;
          mem_addr_o   = word_addr;
          mem_sel_o    = 4'hF;
          result_o     = mem_rdata_i;
          pend_valid_d = 1'b1;
          pend_val_d   = 1'b1;
          pend_addr_d  = word_addr;
        end
        OP_SC: begin
          if (eff_ll && (!CHECK_ADDR || link_hit)) begin
            mem_ce_o     = 1'b1;
            mem_we_o     = 1'b1;
            mem_addr_o   = word_addr;
            mem_sel_o    = 4'hF;
            mem_data_o   = wdata_i;
            result_o     = 32'd1;
            pend_valid_d = 1'b1;
          end
        end
        OP_STORE: begin
          mem_ce_o   = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = word_addr;
          mem_sel_o  = 4'hF;
          mem_data_o = wdata_i;
          if (CHECK_ADDR && link_hit) begin
            pend_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A stalled cycle is replayed, so it must not write now.
    if (stall_i) begin
      mem_we_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_val_q   <= 1'b0;
      pend_addr_q  <= '0;
    end else if (flush_i) begin
      pend_valid_q <= 1'b0;
    end else if (!stall_i) begin
      pend_valid_q <= pend_valid_d;
      pend_val_q   <= pend_val_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign commit = pend_valid_q && !stall_i && !flush_i;

  llbit_reg #(
    .ADDR_W (ADDR_W)
  ) u_llbit_reg (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .commit_i (commit),
    .llbit_i  (pend_val_q),
    .link_i   (pend_addr_q),
    .llbit_o  (llbit_c),
    .link_o   (link_c)
  );

endmodule

// File: doc/llsc_mem_unit.md
Name: llsc_mem_unit

Overview:
- Memory-access-stage helper for the openMIPS core. Turns LL, SC and plain store/load requests from EX/MEM into data_ram bank strobes.
- Owns the LLbit and the link address. Produces the SC success/fail result for the register file.
- Keeps a one-entry commit pipeline, mirroring MEM/WB, with forwarding, so back-to-back LL/SC pairs see the latest LLbit.

Parameters:
- ADDR_W, 32, data address width.
- CHECK_ADDR, 1: when 1, SC also fails if its word address differs from the link address, and a plain store to the linked word clears the LLbit.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  MEM stage holds a memory instruction
- op_i  in  2  00 plain load, 01 LL, 10 SC, 11 plain store (SW)
- addr_i  in  ADDR_W  effective address from EX
- wdata_i  in  32  store data (rt)
- stall_i  in  1  MEM/WB stall; state frozen
- flush_i  in  1  exception/ERET flush; clears LLbit
- mem_rdata_i  in  32  data_ram combinational read data
- mem_ce_o  out  1  data_ram chip enable
- mem_we_o  out  1  data_ram write enable
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_sel_o  out  4  bank0..bank3 byte strobes
- mem_data_o  out  32  write data
- result_o  out  32  value for rt: load data, or SC status 0/1
- llbit_o  out  1  effective LLbit, i.e. after forwarding
- link_addr_o  out  ADDR_W  current link word address

Behaviour:
- Reset values:
  - committed LLbit 0, link address 0, pending entry invalid.
  - All mem_* outputs 0; result_o 0.
  - Reset acts immediately, without waiting for a clock edge. It may be asserted mid-sequence: any pending commit is dropped.
- Effective LLbit: if the pending entry is valid, use its value; otherwise use the committed LLbit. The effective link address is selected the same way.
- Datapath is combinational, same cycle as req_valid_i. mem_addr_o = {addr_i[ADDR_W-1:2], 2'b00}; mem_sel_o = 4'hF for every op when active.
- Plain load:
  - ce=1, we=0; result_o = mem_rdata_i.
- LL:
  - ce=1, we=0; result_o = mem_rdata_i.
  - Schedules LLbit := 1 and link := word address.
- SC, treated as succeeding iff effective LLbit = 1 and (CHECK_ADDR = 0 or word address = effective link):
  - Success: ce=1, we=1, mem_data_o = wdata_i, result_o = 1. Schedules LLbit := 0.
  - Fail: ce=0, we=0, result_o = 0, no LLbit update.
- Plain store:
  - ce=1, we=1, mem_data_o = wdata_i, result_o = 0.
  - If CHECK_ADDR = 1 and word address = effective link, schedules LLbit := 0.
- Scheduling, at each posedge when not stalled:
  - pending takes {valid, value, addr} of the current scheduled update, or becomes invalid if there is none.
  - A previously valid pending entry is written into the committed registers at the same edge (one-cycle commit latency, as the WB stage does).
- stall_i = 1 holds all registers, and mem_we_o is forced to 0 so a stalled cycle cannot write twice. Outputs otherwise stay combinational.
- flush_i = 1 (priority over stall and scheduling):
  - At the next edge, committed LLbit := 0 and pending is invalidated.
  - Link address is retained.
  - The same-cycle request is killed: ce=0, we=0, result_o = 0.
- req_valid_i = 0: all mem_* outputs 0, result_o = 0, nothing scheduled.
- Back-to-back LL then SC: the SC sees the LL's pending value via forwarding and succeeds.
- SC then SC: the second SC sees pending 0 and fails.

Decomposition:
- Shared package/header:
  - op encodings (OP_LOAD, OP_LL, OP_SC, OP_STORE);
  - LLbit reset value;
  - the word-address helper constant (2 LSBs dropped).
- One natural sub-module, llbit_reg: committed LLbit and link address with async reset and flush clear, fed by the pending/commit logic in the parent.

Test Plan:
- Preload mem[0x0] = 0x00001234; LL at addr 0x0 -> result_o = 0x1234; next cycle llbit_o = 1, link_addr_o = 0x0.
- LL 0x0 immediately followed by SC 0x0 with wdata 0x1235 -> SC result_o = 1, mem_we_o = 1, mem_data_o = 0x1235. A following load of 0x0 returns 0x1235, and llbit_o = 0.
- SC to 0x0 with llbit_o = 0 -> result_o = 0, mem_we_o = 0; mem[0x0] unchanged at 0x1234.
- LL 0x0, then SW 0x5678 to 0x0, then SC 0x0 (CHECK_ADDR = 1) -> SC result_o = 0, mem[0x0] = 0x5678. The same sequence with SW to 0x4 -> SC result_o = 1.
- LL 0x0, then flush_i for one cycle, then SC 0x0 -> SC result_o = 0, and llbit_o = 0 after the flush edge. The flushed-cycle request produces no mem_ce_o.
- Assert rst asynchronously between LL and SC -> llbit_o drops to 0 without a clock edge, all outputs 0, and the subsequent SC fails.
